// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for a five-stage MIPS pipeline. It sits
// beside the ID stage and produces the PC / IF/ID / ID/EX write and flush
// controls that every pipeline register samples on the same clock edge.
//
//   * Load-use hazard: ID reads a register that the load in EX is writing.
//   * HI/LO interlock: mult/div or mfhi/mflo in ID while the fixed-latency
//     mult/div unit is still busy (tracked by a small IDLE/BUSY FSM).
//   * Taken branch in EX squashes IF/ID and ID/EX and overrides any stall.
//   * Saturating 16-bit stall-cycle counter for performance debug.
//
// Ports
//   i_clk             system clock, rising edge
//   i_rst_n           asynchronous active-low reset
//   i_id_rs_addr      rs field of the ID instruction
//   i_id_rt_addr      rt field of the ID instruction
//   i_id_uses_rs      ID instruction reads rs
//   i_id_uses_rt      ID instruction reads rt
//   i_id_is_md        ID instruction is mult/multu/div/divu
//   i_id_reads_hilo   ID instruction is mfhi/mflo
//   i_ex_mem_read     EX instruction is a load
//   i_ex_rd_addr      destination register of the EX instruction
//   i_ex_branch_taken branch/jump in EX resolved taken
//   i_stat_clear      synchronous clear of the stall counter
//   o_pc_write        PC load enable                      (combinational)
//   o_if_id_write     IF/ID load enable                   (combinational)
//   o_if_id_flush     IF/ID loads a bubble                (combinational)
//   o_id_ex_flush     ID/EX loads a bubble                (combinational)
//   o_md_start        mult/div issue pulse                (combinational)
//   o_md_busy         mult/div unit busy                  (registered)
//   o_stall_cycles    saturating stall-cycle count        (registered)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4  // busy cycles after issue, 1..255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs_addr,
  input  logic [4:0]  i_id_rt_addr,
  input  logic        i_id_uses_rs,
  input  logic        i_id_uses_rt,
  input  logic        i_id_is_md,
  input  logic        i_id_reads_hilo,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic        i_ex_branch_taken,
  input  logic        i_stat_clear,
  output logic        o_pc_write,
  output logic        o_if_id_write,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_md_start,
  output logic        o_md_busy,
  output logic [15:0] o_stall_cycles
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  localparam logic [7:0]  MD_CNT_INIT = 8'(MD_LATENCY - 1);
  localparam logic [15:0] STALL_MAX   = 16'hFFFF;

  md_state_t   r_md_state;
  logic [7:0]  r_md_cnt;
  logic        r_md_busy;
  logic [15:0] r_stall_cycles;

  logic w_load_hazard;
  logic w_md_hazard;
  logic w_stall;
  logic w_md_start;
  logic w_stall_count_en;

  // Register $0 is hard-wired to zero, so a load targeting it never hazards.
  assign w_load_hazard = i_ex_mem_read && (i_ex_rd_addr != 5'd0) &&
                         ((i_id_uses_rs && (i_id_rs_addr == i_ex_rd_addr)) ||
                          (i_id_uses_rt && (i_id_rt_addr == i_ex_rd_addr)));

  // Any mult/div or HI/LO read must wait until the unit has finished.
  assign w_md_hazard = (i_id_is_md || i_id_reads_hilo) && r_md_busy;
  assign w_stall     = w_load_hazard || w_md_hazard;

  // Pipeline controls. Reset drives a safe bubble state directly, without
  // waiting for a clock, so nothing advances while the core is held in reset.
  always_comb begin
    o_pc_write    = 1'b1;
    o_if_id_write = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    w_md_start    = 1'b0;
    if (!i_rst_n) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (i_ex_branch_taken) begin
      // The ID instruction is squashed, so its stall or mult/div issue is moot.
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_stall) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_id_ex_flush = 1'b1;
    end else begin
      w_md_start    = i_id_is_md;
    end
  end

  assign o_md_start = w_md_start;

  // Mult/div busy tracker. Issue can only happen in IDLE because a mult/div
  // seen while busy is held back by the interlock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_md_state <= ST_IDLE;
      r_md_cnt   <= 8'd0;
      r_md_busy  <= 1'b0;
    end else begin
      case (r_md_state)
        ST_IDLE: begin
          if (w_md_start) begin
            r_md_state <= ST_BUSY;
            r_md_cnt   <= MD_CNT_INIT;
            r_md_busy  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (r_md_cnt == 8'd0) begin
            r_md_state <= ST_IDLE;
            r_md_busy  <= 1'b0;
          end else begin
            r_md_cnt <= r_md_cnt - 8'd1;
          end
        end
        default: begin
          r_md_state <= ST_IDLE;
          r_md_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_md_busy = r_md_busy;

  // A stall overridden by a taken branch is not a lost cycle, so it is not
  // counted. Clear takes precedence over counting.
  assign w_stall_count_en = w_stall && !i_ex_branch_taken &&
                            (r_stall_cycles != STALL_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= 16'd0;
    end else if (i_stat_clear) begin
      r_stall_cycles <= 16'd0;
    end else if (w_stall_count_en) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed plus randomized checks of pipeline_hazard_ctrl against a
// behavioural model: the mult/div unit is modelled as "cycles of busy left",
// the stall counter as a saturating integer.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int MD_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_md;
  logic        id_reads_hilo;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        ex_branch_taken;
  logic        stat_clear;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        md_start;
  logic        md_busy;
  logic [15:0] stall_cycles;

  int n_tests;
  int n_fail;

  // Reference model state
  int m_md_left;   // cycles the unit is still busy for
  int m_stalls;    // saturating stall count

  pipeline_hazard_ctrl #(.MD_LATENCY(MD_LAT)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_id_rs_addr      (id_rs_addr),
    .i_id_rt_addr      (id_rt_addr),
    .i_id_uses_rs      (id_uses_rs),
    .i_id_uses_rt      (id_uses_rt),
    .i_id_is_md        (id_is_md),
    .i_id_reads_hilo   (id_reads_hilo),
    .i_ex_mem_read     (ex_mem_read),
    .i_ex_rd_addr      (ex_rd_addr),
    .i_ex_branch_taken (ex_branch_taken),
    .i_stat_clear      (stat_clear),
    .o_pc_write        (pc_write),
    .o_if_id_write     (if_id_write),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_flush     (id_ex_flush),
    .o_md_start        (md_start),
    .o_md_busy         (md_busy),
    .o_stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs_addr      = 5'd0;
    id_rt_addr      = 5'd0;
    id_uses_rs      = 1'b0;
    id_uses_rt      = 1'b0;
    id_is_md        = 1'b0;
    id_reads_hilo   = 1'b0;
    ex_mem_read     = 1'b0;
    ex_rd_addr      = 5'd0;
    ex_branch_taken = 1'b0;
    stat_clear      = 1'b0;
  endtask

  // One pipeline cycle: inputs are already applied (shortly after a rising
  // edge). Outputs are compared at the falling edge, then the model advances
  // on the rising edge with the same inputs.
  task automatic run_cycle(input string tag, input bit do_check);
    bit lh, mh, st;
    bit e_pc, e_ifw, e_iff, e_idf, e_mds;
    @(negedge clk);
    lh = ex_mem_read && (ex_rd_addr != 5'd0) &&
         ((id_uses_rs && id_rs_addr == ex_rd_addr) ||
          (id_uses_rt && id_rt_addr == ex_rd_addr));
    mh = (id_is_md || id_reads_hilo) && (m_md_left > 0);
    st = lh || mh;
    if (ex_branch_taken) begin
      e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1; e_mds = 0;
    end else if (st) begin
      e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 1; e_mds = 0;
    end else begin
      e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_mds = id_is_md;
    end
    if (do_check) begin
      check({tag, ".pc_write"},     16'(pc_write),    16'(e_pc));
      check({tag, ".if_id_write"},  16'(if_id_write), 16'(e_ifw));
      check({tag, ".if_id_flush"},  16'(if_id_flush), 16'(e_iff));
      check({tag, ".id_ex_flush"},  16'(id_ex_flush), 16'(e_idf));
      check({tag, ".md_start"},     16'(md_start),    16'(e_mds));
      check({tag, ".md_busy"},      16'(md_busy),     16'(m_md_left > 0));
      check({tag, ".stall_cycles"}, stall_cycles,     16'(m_stalls));
      $display("[TB] %s: pc=%b ifw=%b iff=%b idf=%b mds=%b busy=%b stalls=%0d",
               tag, pc_write, if_id_write, if_id_flush, id_ex_flush, md_start,
               md_busy, stall_cycles);
    end
    @(posedge clk);
    if (m_md_left > 0) m_md_left--;
    else if (e_mds) m_md_left = MD_LAT;
    if (stat_clear) m_stalls = 0;
    else if (st && !ex_branch_taken && m_stalls < 65535) m_stalls++;
    #1;
  endtask

  initial begin
    int base;
    n_tests   = 0;
    n_fail    = 0;
    m_md_left = 0;
    m_stalls  = 0;
    clear_inputs();
    rst_n = 1'b0;

    // Reset state
    #12;
    check("reset.pc_write",     16'(pc_write),    16'd0);
    check("reset.if_id_write",  16'(if_id_write), 16'd0);
    check("reset.if_id_flush",  16'(if_id_flush), 16'd1);
    check("reset.id_ex_flush",  16'(id_ex_flush), 16'd1);
    check("reset.md_busy",      16'(md_busy),     16'd0);
    check("reset.stall_cycles", stall_cycles,     16'd0);
    $display("[TB] reset: pc=%b flushes=%b%b busy=%b", pc_write, if_id_flush, id_ex_flush, md_busy);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs
    ex_mem_read = 1; ex_rd_addr = 5'd8; id_rs_addr = 5'd8; id_uses_rs = 1;
    run_cycle("load_use_rs", 1);
    check("load_use_rs.pc_write_low", 16'(pc_write), 16'd0);
    ex_mem_read = 0;  // load moved on, bubble in EX
    run_cycle("load_use_bubble", 1);
    check("load_use.count", stall_cycles, 16'd1);

    // Load to $0 never stalls
    ex_mem_read = 1; ex_rd_addr = 5'd0; id_rs_addr = 5'd0;
    run_cycle("load_r0", 1);

    // Load-use on rt only
    clear_inputs();
    ex_mem_read = 1; ex_rd_addr = 5'd9; id_rt_addr = 5'd9; id_uses_rt = 1;
    id_rs_addr = 5'd9;  // rs matches but is not read
    run_cycle("load_use_rt", 1);
    id_uses_rt = 0;
    run_cycle("rs_unused", 1);

    // Mult/div interlock: issue then mflo waits MD_LAT cycles
    clear_inputs();
    base = m_stalls;
    id_is_md = 1;
    run_cycle("md_issue", 1);
    id_is_md = 0; id_reads_hilo = 1;
    for (int i = 1; i <= MD_LAT + 1; i++) run_cycle($sformatf("mflo_T+%0d", i), 1);
    check("md_interlock.count", stall_cycles, 16'(base + MD_LAT));

    // Branch over load hazard
    clear_inputs();
    base = m_stalls;
    ex_mem_read = 1; ex_rd_addr = 5'd3; id_rs_addr = 5'd3; id_uses_rs = 1;
    ex_branch_taken = 1;
    run_cycle("branch_over_stall", 1);
    check("branch_over_stall.count", stall_cycles, 16'(base));

    // Squashed mult
    clear_inputs();
    id_is_md = 1; ex_branch_taken = 1;
    run_cycle("squashed_md", 1);
    clear_inputs();
    run_cycle("squashed_md_after", 1);
    check("squashed_md.busy", 16'(md_busy), 16'd0);

    // Reset mid-BUSY
    id_is_md = 1;
    run_cycle("md_issue_pre_reset", 1);
    id_is_md = 0;
    run_cycle("md_busy_pre_reset", 1);
    id_is_md = 1;
    #2 rst_n = 1'b0;
    #1;
    m_md_left = 0; m_stalls = 0;
    check("mid_reset.md_busy",      16'(md_busy),     16'd0);
    check("mid_reset.stall_cycles", stall_cycles,     16'd0);
    check("mid_reset.pc_write",     16'(pc_write),    16'd0);
    check("mid_reset.if_id_write",  16'(if_id_write), 16'd0);
    check("mid_reset.if_id_flush",  16'(if_id_flush), 16'd1);
    check("mid_reset.id_ex_flush",  16'(id_ex_flush), 16'd1);
    check("mid_reset.md_start",     16'(md_start),    16'd0);
    $display("[TB] mid_reset: busy=%b stalls=%0d pc=%b", md_busy, stall_cycles, pc_write);
    clear_inputs();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_cycle("post_reset", 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      id_rs_addr      = 5'($urandom_range(0, 3));
      id_rt_addr      = 5'($urandom_range(0, 3));
      ex_rd_addr      = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      id_is_md        = ($urandom_range(0, 5) == 0);
      id_reads_hilo   = ($urandom_range(0, 5) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      stat_clear      = ($urandom_range(0, 15) == 0);
      run_cycle($sformatf("rand_%0d", i), 1);
    end

    // Saturation
    clear_inputs();
    stat_clear = 1;
    run_cycle("sat_clear_start", 1);
    stat_clear = 0;
    ex_mem_read = 1; ex_rd_addr = 5'd5; id_rs_addr = 5'd5; id_uses_rs = 1;
    for (int i = 0; i < 65534; i++) run_cycle("sat_fill", 0);
    run_cycle("sat_last", 1);
    check("sat.at_max", stall_cycles, 16'hFFFF);
    run_cycle("sat_hold", 1);
    check("sat.hold", stall_cycles, 16'hFFFF);
    stat_clear = 1;  // clear wins over a concurrent stall
    run_cycle("sat_clear", 1);
    stat_clear = 0;
    clear_inputs();
    run_cycle("sat_after_clear", 1);
    check("sat.cleared", stall_cycles, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
